// File: rtl/fibo_request_sequencer.sv
// Fibonacci request sequencer: FIFO-buffered START/DONE initiator.
// Optional watchdog enabled by defining FIBO_TIMEOUT_EN.
module fibo_request_sequencer #(
  parameter int SIZE     = 4,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SIZE-1:0] req_count,
  output logic            START,
  output logic [SIZE-1:0] count,
  input  logic            DONE,
  input  logic [SIZE-1:0] data_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SIZE-1:0] rsp_count,
  output logic [SIZE-1:0] rsp_data,
  output logic            rsp_err,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            timeout;
  logic            finish;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && !empty;
  assign finish    = (state == S_WAIT) && (DONE || timeout);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= req_count;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef FIBO_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wait_cnt <= '0;
    end else if (state == S_ARM) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Fires on the WAIT cycle whose increment would reach the limit
  assign timeout = (state == S_WAIT) && !DONE &&
                   (wait_cnt == CW'(MAX_WAIT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (!empty) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_ARM;
      S_ARM:   state_nx = S_WAIT;
      S_WAIT:  if (DONE || timeout) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    START = (state == S_ISSUE);
    busy  = (state != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_count <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop) begin
        count <= mem[rd_ptr[AW-1:0]];
      end
      if (finish) begin
        rsp_valid <= 1'b1;
        rsp_count <= count;
        rsp_data  <= DONE ? data_out : '0;
        rsp_err   <= timeout;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
